// File: rtl/serial_pe_feeder.sv
// Operand sequencer for serial_pe: reads a neuron vector and num_out
// weight rows, and streams bubble-free operand pairs with PE control codes.
module serial_pe_feeder #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [LEN_W-1:0]  num_out,
    input  logic [ADDR_W-1:0] neuron_base,
    input  logic [ADDR_W-1:0] weight_base,
    output logic              busy,
    output logic              done,
    output logic              neuron_ren,
    output logic [ADDR_W-1:0] neuron_addr,
    input  logic [15:0]       neuron_rdata,
    output logic              weight_ren,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [15:0]       weight_rdata,
    output logic [15:0]       pe_neuron,
    output logic [15:0]       pe_weight,
    output logic [1:0]        pe_ctl,
    output logic              pe_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [LEN_W-1:0]  LONE = LEN_W'(1);
    localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);

    localparam logic [1:0] CTL_FIRST  = 2'b00;
    localparam logic [1:0] CTL_MID    = 2'b01;
    localparam logic [1:0] CTL_LAST   = 2'b10;
    localparam logic [1:0] CTL_SINGLE = 2'b11;

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_nout;
    logic [LEN_W-1:0]  r_i;
    logic [LEN_W-1:0]  r_o;
    logic [ADDR_W-1:0] r_nbase;
    logic [1:0]        r_ictl;
    logic              r_ivld;

    logic              w_job_ok;
    logic              w_last_i;
    logic              w_last_o;
    logic [LEN_W-1:0]  w_next_i;
    logic              w_next_last;
    logic [1:0]        w_first_ctl;

    assign w_job_ok    = (vec_len != '0) && (num_out != '0);
    assign w_last_i    = (r_i == r_len - LONE);
    assign w_last_o    = (r_o == r_nout - LONE);
    assign w_next_i    = r_i + LONE;
    assign w_next_last = (w_next_i == r_len - LONE);
    assign w_first_ctl = (r_len == LONE) ? CTL_SINGLE : CTL_FIRST;

    // r_ivld/r_ictl describe the read issued this cycle; they are delayed
    // one more stage into pe_vld/pe_ctl so they line up with rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_nout      <= '0;
            r_i         <= '0;
            r_o         <= '0;
            r_nbase     <= '0;
            r_ictl      <= CTL_FIRST;
            r_ivld      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            neuron_ren  <= 1'b0;
            weight_ren  <= 1'b0;
            neuron_addr <= '0;
            weight_addr <= '0;
            pe_ctl      <= CTL_FIRST;
            pe_vld      <= 1'b0;
        end else begin
            done   <= 1'b0;
            pe_vld <= r_ivld;
            pe_ctl <= r_ictl;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_job_ok) begin
                            r_state     <= S_RUN;
                            r_len       <= vec_len;
                            r_nout      <= num_out;
                            r_nbase     <= neuron_base;
                            r_i         <= '0;
                            r_o         <= '0;
                            busy        <= 1'b1;
                            neuron_ren  <= 1'b1;
                            weight_ren  <= 1'b1;
                            neuron_addr <= neuron_base;
                            weight_addr <= weight_base;
                            r_ivld      <= 1'b1;
                            r_ictl      <= (vec_len == LONE) ?
                                           CTL_SINGLE : CTL_FIRST;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last_i) begin
                        if (w_last_o) begin
                            r_state    <= S_DRAIN;
                            neuron_ren <= 1'b0;
                            weight_ren <= 1'b0;
                            r_ivld     <= 1'b0;
                            r_ictl     <= CTL_FIRST;
                        end else begin
                            r_o         <= r_o + LONE;
                            r_i         <= '0;
                            neuron_addr <= r_nbase;
                            weight_addr <= weight_addr + AONE;
                            r_ictl      <= w_first_ctl;
                        end
                    end else begin
                        r_i         <= w_next_i;
                        neuron_addr <= neuron_addr + AONE;
                        weight_addr <= weight_addr + AONE;
                        r_ictl      <= w_next_last ? CTL_LAST : CTL_MID;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pe_neuron = pe_vld ? neuron_rdata : '0;
    assign pe_weight = pe_vld ? weight_rdata : '0;

endmodule

// File: tb/tb_serial_pe_feeder.sv
// Scoreboard bench for serial_pe_feeder with one-cycle-latency memory models
// and a behavioural PE accumulating the streamed operands.
module tb_serial_pe_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  vec_len;
    logic [9:0]  num_out;
    logic [9:0]  neuron_base;
    logic [9:0]  weight_base;
    logic        busy;
    logic        done;
    logic        neuron_ren;
    logic [9:0]  neuron_addr;
    logic [15:0] neuron_rdata;
    logic        weight_ren;
    logic [9:0]  weight_addr;
    logic [15:0] weight_rdata;
    logic [15:0] pe_neuron;
    logic [15:0] pe_weight;
    logic [1:0]  pe_ctl;
    logic        pe_vld;

    typedef struct {
        logic [15:0] n;
        logic [15:0] w;
        logic [1:0]  ctl;
    } op_t;

    op_t        q[$];
    logic [15:0] nmem[1024];
    logic [15:0] wmem[1024];
    int         checks;
    int         errors;
    longint     psum;
    longint     last_result;
    int         n_results;

    serial_pe_feeder #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .vec_len(vec_len),
        .num_out(num_out),
        .neuron_base(neuron_base),
        .weight_base(weight_base),
        .busy(busy),
        .done(done),
        .neuron_ren(neuron_ren),
        .neuron_addr(neuron_addr),
        .neuron_rdata(neuron_rdata),
        .weight_ren(weight_ren),
        .weight_addr(weight_addr),
        .weight_rdata(weight_rdata),
        .pe_neuron(pe_neuron),
        .pe_weight(pe_weight),
        .pe_ctl(pe_ctl),
        .pe_vld(pe_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (neuron_ren) neuron_rdata <= nmem[neuron_addr];
        if (weight_ren) weight_rdata <= wmem[weight_addr];
    end

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({busy, done, neuron_ren, weight_ren, pe_vld} !== 5'b0 ||
            neuron_addr !== 10'd0 || weight_addr !== 10'd0 ||
            pe_ctl !== 2'b00 || pe_neuron !== 16'd0 ||
            pe_weight !== 16'd0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b ren=%b%b vld=%b na=%0d wa=%0d ctl=%b pn=%h pw=%h, required all zero",
                     tag, busy, done, neuron_ren, weight_ren, pe_vld,
                     neuron_addr, weight_addr, pe_ctl, pe_neuron, pe_weight);
        end
    endtask

    // Drives one accepted job and checks every cycle 1..N+2 against the model.
    task automatic run_job(input logic [9:0] len, input logic [9:0] nout,
                           input logic [9:0] nb, input logic [9:0] wb,
                           input bit restart, input string tag);
        int          n_el;
        logic [9:0]  ea;
        logic [1:0]  ectl;
        op_t         op;
        op_t         got;
        n_el = int'(len) * int'(nout);
        q.delete();
        for (int o = 0; o < int'(nout); o++) begin
            for (int i = 0; i < int'(len); i++) begin
                ectl = (len == 10'd1) ? 2'b11 :
                       (i == 0) ? 2'b00 :
                       (i == int'(len) - 1) ? 2'b10 : 2'b01;
                ea = nb + 10'(i);
                op.n = nmem[ea];
                ea = wb + 10'(o * int'(len) + i);
                op.w = wmem[ea];
                op.ctl = ectl;
                q.push_back(op);
            end
        end
        vec_len = len;
        num_out = nout;
        neuron_base = nb;
        weight_base = wb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        psum = 0;
        n_results = 0;
        for (int c = 1; c <= n_el + 2; c++) begin
            int k;
            k = c - 1;
            checks++;
            if (neuron_ren !== (c <= n_el) || weight_ren !== (c <= n_el)) begin
                errors++;
                $display("FAIL %s ren c=%0d: got %b%b, required %0d",
                         tag, c, neuron_ren, weight_ren, (c <= n_el));
            end
            if (c <= n_el) begin
                checks++;
                if (neuron_addr !== nb + 10'(k % int'(len)) ||
                    weight_addr !== wb + 10'(k)) begin
                    errors++;
                    $display("FAIL %s addr c=%0d: got n=%0d w=%0d, required n=%0d w=%0d",
                             tag, c, neuron_addr, weight_addr,
                             nb + 10'(k % int'(len)), wb + 10'(k));
                end
            end
            checks++;
            if (busy !== (c <= n_el + 1) || done !== (c == n_el + 2)) begin
                errors++;
                $display("FAIL %s busy/done c=%0d: got %b/%b, required %0d/%0d",
                         tag, c, busy, done, (c <= n_el + 1), (c == n_el + 2));
            end
            checks++;
            if (pe_vld !== (c >= 2 && c <= n_el + 1)) begin
                errors++;
                $display("FAIL %s pe_vld c=%0d: got %b, required %0d",
                         tag, c, pe_vld, (c >= 2 && c <= n_el + 1));
            end
            if (pe_vld === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard c=%0d: got extra operand, required none",
                             tag, c);
                end else begin
                    got = q.pop_front();
                    if (pe_ctl !== got.ctl || pe_neuron !== got.n ||
                        pe_weight !== got.w) begin
                        errors++;
                        $display("FAIL %s operand c=%0d: got ctl=%b n=%h w=%h, required ctl=%b n=%h w=%h",
                                 tag, c, pe_ctl, pe_neuron, pe_weight,
                                 got.ctl, got.n, got.w);
                    end
                    if (pe_ctl == 2'b00 || pe_ctl == 2'b11)
                        psum = longint'($signed(pe_neuron)) *
                               longint'($signed(pe_weight));
                    else
                        psum += longint'($signed(pe_neuron)) *
                                longint'($signed(pe_weight));
                    if (pe_ctl[1]) begin
                        last_result = psum;
                        n_results++;
                    end
                end
            end else begin
                checks++;
                if (pe_neuron !== 16'd0 || pe_weight !== 16'd0) begin
                    errors++;
                    $display("FAIL %s gated operand c=%0d: got %h/%h, required 0/0",
                             tag, c, pe_neuron, pe_weight);
                end
            end
            if (restart && c == 2) begin
                vec_len = len + 10'd3;
                num_out = nout + 10'd2;
                neuron_base = nb + 10'd50;
                weight_base = wb + 10'd77;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0 || n_results != int'(nout)) begin
            errors++;
            $display("FAIL %s completion: got %0d left, %0d results, required 0 left, %0d results",
                     tag, q.size(), n_results, nout);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pe_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s post-job: got done=%b busy=%b vld=%b, required 0",
                     tag, done, busy, pe_vld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_basic();
        nmem[0] = 16'd2;
        nmem[1] = -16'sd3;
        nmem[2] = 16'd4;
        wmem[16] = 16'd5;
        wmem[17] = 16'd6;
        wmem[18] = -16'sd7;
        run_job(10'd3, 10'd1, 10'd0, 10'd16, 1'b0, "basic");
        checks++;
        if (last_result != -64'sd36) begin
            errors++;
            $display("FAIL basic dot: got %0d, required -36", last_result);
        end
    endtask

    task automatic test_multi();
        run_job(10'd2, 10'd3, 10'd0, 10'd100, 1'b0, "multi");
    endtask

    task automatic test_single();
        run_job(10'd1, 10'd2, 10'd7, 10'd300, 1'b0, "single");
    endtask

    task automatic test_zero(input logic [9:0] len, input logic [9:0] nout,
                             input string tag);
        vec_len = len;
        num_out = nout;
        neuron_base = 10'd5;
        weight_base = 10'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (done !== (c == 1) || busy !== 1'b0 ||
                neuron_ren !== 1'b0 || weight_ren !== 1'b0 ||
                pe_vld !== 1'b0) begin
                errors++;
                $display("FAIL %s c=%0d: got done=%b busy=%b ren=%b%b vld=%b, required done=%0d others 0",
                         tag, c, done, busy, neuron_ren, weight_ren, pe_vld,
                         (c == 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        run_job(10'd4, 10'd2, 10'd20, 10'd500, 1'b1, "restart");
    endtask

    task automatic test_wrap();
        run_job(10'd4, 10'd1, 10'd1021, 10'd1022, 1'b0, "wrap");
    endtask

    task automatic test_reset_mid();
        vec_len = 10'd8;
        num_out = 10'd1;
        neuron_base = 10'd40;
        weight_base = 10'd600;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || neuron_ren !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: got busy=%b ren=%b, required 1/1",
                     busy, neuron_ren);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle_outputs("reset_mid_quiet");
        end
        run_job(10'd8, 10'd1, 10'd40, 10'd600, 1'b0, "post_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_result = 0;
        vec_len = '0;
        num_out = '0;
        neuron_base = '0;
        weight_base = '0;
        for (int a = 0; a < 1024; a++) begin
            nmem[a] = 16'($urandom);
            wmem[a] = 16'($urandom);
        end
        test_reset();
        test_basic();
        test_multi();
        test_single();
        test_zero(10'd0, 10'd5, "zero_len");
        test_zero(10'd3, 10'd0, "zero_out");
        test_restart();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
